rv_rr_arbiter: RTL and testbench

- N-input round-robin arbiter that merges NREQ ready/valid request streams onto one ready/valid output stream.
- Supports packet locking through a per-input last flag: once a multi-beat packet starts, the grant holds until its last beat.
- The output is registered as a one-entry holding stage, so the merged stream feeds downstream sinks with one cycle of latency.
- Sits between multiple stream sources and a shared consumer, e.g. several sources feeding one sink.

---
 rtl/rv_rr_arbiter_pkg.sv | 14 +
 rtl/rv_rr_arbiter_rr_pick.sv | 31 +++
 rtl/rv_rr_arbiter.sv | 105 ++++++++++
 tb/tb_rv_rr_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_rr_arbiter_pkg.sv
// Shared types and elaboration helpers for the ready/valid round-robin arbiter.
package rv_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // Source index must be able to name every requester.
   function automatic bit params_ok(input int nreq, input int srcw);
      return (nreq >= 2) && ((1 << srcw) >= nreq);
   endfunction

endpackage

// File: rtl/rv_rr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int SRCW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [SRCW-1:0] ptr,
   input  logic            en,
   output logic [SRCW-1:0] grant,
   output logic            any_grant
);

   int unsigned idx;

   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      idx       = 0;
      if (en) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_grant && req[idx]) begin
               any_grant = 1'b1;
               grant     = SRCW'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin merge of NREQ ready/valid streams with packet locking and a one-entry output register.
module rv_rr_arbiter
   import rv_rr_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NBITS = 32,
   parameter int SRCW  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic [NREQ-1:0]       inReady_o,
   input  logic [NREQ-1:0]       inValid_i,
   input  logic [NREQ*NBITS-1:0] inData_i,
   input  logic [NREQ-1:0]       inLast_i,
   input  logic                  outReady_i,
   output logic                  outValid_o,
   output logic [NBITS-1:0]      outData_o,
   output logic                  outLast_o,
   output logic [SRCW-1:0]       outSrc_o,
   output logic                  locked_o
);

   if (!params_ok(NREQ, SRCW)) begin : g_bad_params
      $error("rv_rr_arbiter: NREQ must be >= 2 and 2**SRCW >= NREQ");
   end

   arb_state_t        state;
   logic [SRCW-1:0]   ptr;
   logic [SRCW-1:0]   lock_idx;
   logic              slot_free;
   logic              accept;
   logic [SRCW-1:0]   grant;
   logic              any_grant;
   logic [NBITS-1:0]  sel_data;
   logic              sel_last;
   logic [SRCW-1:0]   sel_src;

   assign slot_free = !outValid_o || outReady_i;

   rr_pick #(
      .NREQ(NREQ),
      .SRCW(SRCW)
   ) u_pick (
      .req      (inValid_i),
      .ptr      (ptr),
      .en       (slot_free && (state == ST_IDLE)),
      .grant    (grant),
      .any_grant(any_grant)
   );

   // inReady_o is one-hot or zero, so the data mux is a plain OR-free priority scan.
   always_comb begin
      inReady_o = '0;
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_src   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!rst_i && slot_free) begin
            if (state == ST_IDLE)
               inReady_o[k] = any_grant && (grant == SRCW'(k));
            else
               inReady_o[k] = inValid_i[k] && (lock_idx == SRCW'(k));
         end
         if (inReady_o[k]) begin
            sel_data = inData_i[k*NBITS +: NBITS];
            sel_last = inLast_i[k];
            sel_src  = SRCW'(k);
         end
      end
   end

   assign accept   = |inReady_o;
   assign locked_o = (state == ST_LOCKED);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         lock_idx   <= '0;
         outValid_o <= 1'b0;
         outData_o  <= '0;
         outLast_o  <= 1'b0;
         outSrc_o   <= '0;
      end else if (accept) begin
         outValid_o <= 1'b1;
         outData_o  <= sel_data;
         outLast_o  <= sel_last;
         outSrc_o   <= sel_src;
         case (state)
            ST_IDLE: begin
               ptr <= (sel_src == SRCW'(NREQ-1)) ? '0 : sel_src + SRCW'(1);
               if (!sel_last) begin
                  state    <= ST_LOCKED;
                  lock_idx <= sel_src;
               end
            end
            ST_LOCKED: if (sel_last) state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end else if (outReady_i) begin
         outValid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_rv_rr_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   in_ready, in_valid, in_last;
   logic [127:0] in_data;
   logic         out_ready, out_valid, out_last, locked;
   logic [31:0]  out_data;
   logic [1:0]   out_src;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: held output beat plus arbitration bookkeeping.
   bit        m_valid, m_last, m_locked;
   logic [31:0] m_data;
   int        m_src, m_ptr, m_lock;

   bit          fetched;
   logic [31:0] fetch_data;
   logic [1:0]  fetch_src;

   always #5 clk = ~clk;

   rv_rr_arbiter #(
      .NREQ (4),
      .NBITS(32),
      .SRCW (2)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .inReady_o (in_ready),
      .inValid_i (in_valid),
      .inData_i  (in_data),
      .inLast_i  (in_last),
      .outReady_i(out_ready),
      .outValid_o(out_valid),
      .outData_o (out_data),
      .outLast_o (out_last),
      .outSrc_o  (out_src),
      .locked_o  (locked)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_last = 0; m_locked = 0; m_data = '0;
      m_src = 0; m_ptr = 0; m_lock = 0;
   endtask

   // Called at a negedge with inputs applied; checks, advances the model across the next posedge.
   task automatic step();
      logic [3:0] er;
      int acc;
      #1;
      er  = '0;
      acc = -1;
      if (!m_valid || out_ready) begin
         if (m_locked) begin
            if (in_valid[m_lock]) acc = m_lock;
         end else begin
            for (int off = 0; off < 4 && acc < 0; off++)
               if (in_valid[(m_ptr + off) % 4]) acc = (m_ptr + off) % 4;
         end
      end
      if (acc >= 0) er[acc] = 1'b1;
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, m_valid);
      chk("locked", locked, m_locked);
      if (m_valid) begin
         chk("out_data", out_data, m_data);
         chk("out_last", out_last, m_last);
         chk("out_src", out_src, m_src);
      end
      fetched    = out_valid && out_ready;
      fetch_data = out_data;
      fetch_src  = out_src;
      if (acc >= 0) begin
         if (!m_locked) begin
            m_ptr = (acc + 1) % 4;
            if (!in_last[acc]) begin m_locked = 1; m_lock = acc; end
         end else if (in_last[acc]) begin
            m_locked = 0;
         end
         m_valid = 1;
         m_data  = in_data[acc*32 +: 32];
         m_last  = in_last[acc];
         m_src   = acc;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      int cnt;
      rst = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = '0; out_ready = 1'b1;
      model_reset();
      #3;
      chk("rst_ready", in_ready, 4'h0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 32'h0);
      chk("rst_locked", locked, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Fairness: all valid, single beats.
      for (int n = 0; n < 12; n++) begin
         for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'(32'h100 * k + n);
         step();
         if (n >= 1) begin
            chk("fair_fetch", fetched, 1'b1);
            chk("fair_src", fetch_src, (n - 1) % 4);
            chk("fair_data", fetch_data, 32'(32'h100 * ((n - 1) % 4) + (n - 1)));
         end
      end
      in_valid = 4'h0; step();

      // Packet lock: req0 3-beat packet, req1 waiting.
      for (int c = 0; c < 4; c++) begin
         in_valid = (c < 3) ? 4'b0011 : 4'b0010;
         in_last  = {3'b111, (c == 2)};
         for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'(32'h1000 * k + c);
         #1;
         chk("lock_ready", in_ready, (c < 3) ? 4'b0001 : 4'b0010);
         chk("lock_flag", locked, (c == 1 || c == 2));
         step();
      end
      in_valid = 4'h0; in_last = 4'hF; step();

      // Backpressure with a single beat from req2.
      in_valid = 4'b0100; in_data[64 +: 32] = 32'hDEADBEEF; step();
      in_valid = 4'hF; out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_data", out_data, 32'hDEADBEEF);
         chk("bp_ready", in_ready, 4'h0);
         chk("bp_valid", out_valid, 1'b1);
         step();
      end
      in_valid = 4'h0; out_ready = 1'b1; step();
      chk("bp_release", fetched, 1'b1);
      chk("bp_rel_data", fetch_data, 32'hDEADBEEF);
      step();

      // Wrap-around: req3 then {req0, req3}.
      in_valid = 4'b1000; #1; chk("wrap_g3", in_ready, 4'b1000); step();
      in_valid = 4'b1001; #1; chk("wrap_g0", in_ready, 4'b0001); step();
      #1; chk("wrap_g3b", in_ready, 4'b1000); step();
      in_valid = 4'h0; step();

      // Reset in the middle of a req1 packet.
      in_valid = 4'b0010; in_last = 4'h0; step(); step();
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_data", out_data, 32'h0);
      chk("mid_rst_src", out_src, 2'd0);
      chk("mid_rst_last", out_last, 1'b0);
      chk("mid_rst_locked", locked, 1'b0);
      chk("mid_rst_ready", in_ready, 4'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      in_valid = 4'b0111; in_last = 4'hF;
      #1; chk("post_rst_grant", in_ready, 4'b0001);
      step();
      in_valid = 4'h0; step();

      // Single requester streaming.
      cnt = 0;
      for (int i = 0; i <= 64; i++) begin
         in_valid = (i < 64) ? 4'b0100 : 4'b0000;
         in_data[64 +: 32] = 32'(i);
         step();
         if (fetched) begin
            chk("stream_data", fetch_data, 32'(cnt));
            chk("stream_src", fetch_src, 2'd2);
            cnt++;
         end
      end
      chk("stream_count", cnt, 64);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         in_valid  = 4'($urandom);
         in_last   = 4'($urandom);
         for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = $urandom;
         out_ready = ($urandom_range(3) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
